div_operand_sequencer: RTL and testbench

//  Clocked front/back end for the combinational signed 8-bit restoring divider (divres).

---
 rtl/div_pkg.sv | 18 +
 rtl/div_result_fifo.sv | 62 ++++++
 rtl/div_operand_sequencer.sv | 118 +++++++++++
 tb/tb_div_operand_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider operand sequencer slice.
package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  typedef struct packed {
    logic [DIV_W-1:0] quo;
    logic [DIV_W-1:0] rem;
    logic             dz;
    logic             ovf;
  } result_t;

endpackage

// File: rtl/div_result_fifo.sv
// Synchronous result FIFO, DEPTH entries of result_t (DEPTH a power of 2).
// Pointers wrap naturally at the pointer width; count is one bit wider.
module div_result_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  result_t                    din,
  input  logic                       pop,
  output result_t                    dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  result_t        mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == NW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // Storage array: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_operand_sequencer.sv
// Clocked front/back end for the combinational signed restoring divider.
// Accepts one operand pair at a time, holds it on div_q/div_m for SETTLE_CYCLES,
// then captures quotient/remainder and flags into a small output FIFO.
// Optional feature: define DIV_ZERO_TRAP_EN to replace divide-by-zero results
// with quo=0, rem=dividend, dz=1.
module div_operand_sequencer
  import div_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int OUT_DEPTH     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] in_dividend,
  input  logic [DIV_W-1:0] in_divisor,
  output logic [DIV_W-1:0] div_q,
  output logic [DIV_W-1:0] div_m,
  input  logic [DIV_W-1:0] div_quo,
  input  logic [DIV_W-1:0] div_rem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] out_quo,
  output logic [DIV_W-1:0] out_rem,
  output logic             out_dz,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int NW = $clog2(OUT_DEPTH) + 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  result_t         cap;
  result_t         head;
  logic            accept;
  logic            capture;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [NW-1:0]   fifo_count;

  assign in_ready  = ~rst & (state == IDLE) & (fifo_count < NW'(OUT_DEPTH));
  assign accept    = in_valid & in_ready;
  assign capture   = (state == SETTLE) && (cnt == '0);
  assign fifo_push = capture & ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign fifo_pop  = out_valid & out_ready;
  assign busy      = (state != IDLE);

  assign out_quo = head.quo;
  assign out_rem = head.rem;
  assign out_dz  = head.dz;
  assign out_ovf = head.ovf;

  // Build the entry to capture from the held operands and the divider outputs.
  always_comb begin
    cap.quo = div_quo;
    cap.rem = div_rem;
    cap.dz  = 1'b0;
    cap.ovf = (div_q == 8'h80) && (div_m == 8'hFF);
`ifdef DIV_ZERO_TRAP_EN
    if (div_m == '0) begin
      cap.quo = '0;
      cap.rem = div_q;
      cap.dz  = 1'b1;
    end
`else
`endif
  end

  // Sequencer FSM: latch operands on accept, count down the settle time, then return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      div_q <= '0;
      div_m <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_q <= in_dividend;
            div_m <= in_divisor;
            cnt   <= CW'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  div_result_fifo #(
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (cap),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Testbench for div_operand_sequencer: instance 0 uses SETTLE_CYCLES=1, instance 1
// uses SETTLE_CYCLES=3, both OUT_DEPTH=2, each tied to a behavioural divres model.
module tb_div_operand_sequencer;

  typedef struct {
    logic [7:0] quo;
    logic [7:0] rem;
    logic       dz;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_dividend [2];
  logic [7:0] in_divisor  [2];
  logic [7:0] div_q   [2];
  logic [7:0] div_m   [2];
  logic [7:0] div_quo [2];
  logic [7:0] div_rem [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_quo [2];
  logic [7:0] out_rem [2];
  logic       out_dz  [2];
  logic       out_ovf [2];
  logic       busy    [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   tests;
  int   failed;

  // Stand-in for the divres divider: truncating signed division, M=0 gives quo=FF, rem=Q.
  function automatic logic [15:0] divres_model(input logic [7:0] q, input logic [7:0] m);
    int a;
    int b;
    logic [7:0] qq;
    logic [7:0] rr;
    a = $signed(q);
    b = $signed(m);
    if (m == 8'h00) begin
      qq = 8'hFF;
      rr = q;
    end else begin
      qq = 8'(a / b);
      rr = 8'(a % b);
    end
    return {qq, rr};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int SC = (g == 0) ? 1 : 3;
    assign {div_quo[g], div_rem[g]} = divres_model(div_q[g], div_m[g]);
    div_operand_sequencer #(
      .SETTLE_CYCLES(SC),
      .OUT_DEPTH(2)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_dividend(in_dividend[g]),
      .in_divisor (in_divisor[g]),
      .div_q      (div_q[g]),
      .div_m      (div_m[g]),
      .div_quo    (div_quo[g]),
      .div_rem    (div_rem[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_quo    (out_quo[g]),
      .out_rem    (out_rem[g]),
      .out_dz     (out_dz[g]),
      .out_ovf    (out_ovf[g]),
      .busy       (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic compareHead(input int sel, input exp_t e);
    checkOutput($sformatf("dut%0d_quo", sel), out_quo[sel], e.quo);
    checkOutput($sformatf("dut%0d_rem", sel), out_rem[sel], e.rem);
    checkOutput($sformatf("dut%0d_dz", sel), 8'(out_dz[sel]), 8'(e.dz));
    checkOutput($sformatf("dut%0d_ovf", sel), 8'(out_ovf[sel]), 8'(e.ovf));
  endtask

  // Monitor for instance 0: every pop is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid[0] && out_ready[0]) begin
      if (sb0.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL dut0_unexpected_pop: got quo=%h rem=%h expected no entry", out_quo[0], out_rem[0]);
      end else begin
        compareHead(0, sb0.pop_front());
      end
    end
  end

  // Monitor for instance 1.
  always @(negedge clk) begin
    if (!rst && out_valid[1] && out_ready[1]) begin
      if (sb1.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL dut1_unexpected_pop: got quo=%h rem=%h expected no entry", out_quo[1], out_rem[1]);
      end else begin
        compareHead(1, sb1.pop_front());
      end
    end
  end

  // Offer one operand pair; on acceptance queue its hand-computed result.
  task automatic applyStimulus(input int sel, input logic [7:0] dvd, input logic [7:0] dvs,
                               input logic [7:0] eq, input logic [7:0] er,
                               input logic edz, input logic eovf);
    logic rdy;
    bit   accepted;
    exp_t e;
    accepted = 0;
    in_dividend[sel] = dvd;
    in_divisor[sel]  = dvs;
    in_valid[sel]    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rdy = in_ready[sel];
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted = 1;
        break;
      end
    end
    in_valid[sel] = 1'b0;
    if (accepted) begin
      e.quo = eq;
      e.rem = er;
      e.dz  = edz;
      e.ovf = eovf;
      if (sel == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end else begin
      tests++;
      failed++;
      $display("[TB] FAIL dut%0d_accept_timeout: got no accept expected accept for %h/%h", sel, dvd, dvs);
    end
  endtask

  task automatic waitDrain(input int sel);
    bit drained;
    drained = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (((sel == 0) ? sb0.size() : sb1.size()) == 0 && !out_valid[sel] && !busy[sel]) begin
        drained = 1;
        break;
      end
    end
    checkOutput($sformatf("dut%0d_drained", sel), 8'(drained), 8'd1);
  endtask

  // Accept 100/7, then check out_valid rises exactly settle edges later.
  task automatic runLatency(input int sel, input int settle);
    out_ready[sel] = 1'b1;
    applyStimulus(sel, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0);
    checkOutput($sformatf("dut%0d_busy_after_accept", sel), 8'(busy[sel]), 8'd1);
    for (int k = 1; k <= settle; k++) begin
      checkOutput($sformatf("dut%0d_valid_before_edge%0d", sel, k), 8'(out_valid[sel]), 8'd0);
      @(posedge clk);
      #1;
    end
    checkOutput($sformatf("dut%0d_valid_at_capture", sel), 8'(out_valid[sel]), 8'd1);
    checkOutput($sformatf("dut%0d_busy_at_capture", sel), 8'(busy[sel]), 8'd0);
    waitDrain(sel);
  endtask

  // Offer three ops with the consumer stalled, then release it.
  task automatic runBackpressure(input int sel);
    out_ready[sel] = 1'b0;
    fork
      begin
        applyStimulus(sel, 8'h0A, 8'h03, 8'h03, 8'h01, 1'b0, 1'b0);
        applyStimulus(sel, 8'hF7, 8'h02, 8'hFC, 8'hFF, 1'b0, 1'b0);
        applyStimulus(sel, 8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0);
      end
      begin
        repeat (12) @(posedge clk);
        #2;
        checkOutput($sformatf("dut%0d_full_in_ready", sel), 8'(in_ready[sel]), 8'd0);
        checkOutput($sformatf("dut%0d_full_out_valid", sel), 8'(out_valid[sel]), 8'd1);
        checkOutput($sformatf("dut%0d_full_busy", sel), 8'(busy[sel]), 8'd0);
        checkOutput($sformatf("dut%0d_full_queued", sel),
                    8'((sel == 0) ? sb0.size() : sb1.size()), 8'd2);
        out_ready[sel] = 1'b1;
      end
    join
    waitDrain(sel);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]    = 1'b0;
      in_dividend[i] = 8'h00;
      in_divisor[i]  = 8'h00;
      out_ready[i]   = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("dut%0d_rst_in_ready", i), 8'(in_ready[i]), 8'd0);
      checkOutput($sformatf("dut%0d_rst_busy", i), 8'(busy[i]), 8'd0);
      checkOutput($sformatf("dut%0d_rst_out_valid", i), 8'(out_valid[i]), 8'd0);
      checkOutput($sformatf("dut%0d_rst_div_q", i), div_q[i], 8'h00);
      checkOutput($sformatf("dut%0d_rst_div_m", i), div_m[i], 8'h00);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("dut0_idle_in_ready", 8'(in_ready[0]), 8'd1);

    // 100/7 with SETTLE_CYCLES=1
    runLatency(0, 1);

    // Signed quadrants back-to-back, in issue order
    out_ready[0] = 1'b1;
    applyStimulus(0, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);
    applyStimulus(0, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
    applyStimulus(0, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);
    waitDrain(0);

    // -128 / -1 overflow
    applyStimulus(0, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
    waitDrain(0);

    // Divide by zero
`ifdef DIV_ZERO_TRAP_EN
    applyStimulus(0, 8'h2A, 8'h00, 8'h00, 8'h2A, 1'b1, 1'b0);
`else
    applyStimulus(0, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b0, 1'b0);
`endif
    waitDrain(0);

    // Backpressure with a two-entry FIFO
    runBackpressure(0);

    // Reset during SETTLE with one entry queued
    out_ready[0] = 1'b0;
    applyStimulus(0, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 8'h0A, 8'h03, 8'h03, 8'h01, 1'b0, 1'b0);
    checkOutput("dut0_pre_rst_busy", 8'(busy[0]), 8'd1);
    rst = 1'b1;
    sb0.delete();
    sb1.delete();
    @(posedge clk);
    #1;
    checkOutput("dut0_midrst_out_valid", 8'(out_valid[0]), 8'd0);
    checkOutput("dut0_midrst_busy", 8'(busy[0]), 8'd0);
    checkOutput("dut0_midrst_div_q", div_q[0], 8'h00);
    checkOutput("dut0_midrst_div_m", div_m[0], 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("dut0_postrst_out_valid", 8'(out_valid[0]), 8'd0);
    out_ready[0] = 1'b1;
    applyStimulus(0, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);
    waitDrain(0);

    // SETTLE_CYCLES=3 instance
    runLatency(1, 3);
    runBackpressure(1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
